// File: rtl/match_controller.sv
// Round/match sequencer for the two-player fight: intro countdown, round timer,
// KO/timeout decision, win tally and match-over, all paced by frame_tick.
module match_controller #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned ROUND_SECONDS  = 99,
  parameter int unsigned INTRO_FRAMES   = 120,
  parameter int unsigned KO_FRAMES      = 90,
  parameter int unsigned WINS_TO_MATCH  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic [2:0] player1_health,
  input  logic [2:0] player2_health,
  output logic       health_rst,
  output logic       fight_enable,
  output logic [2:0] state,
  output logic [3:0] round_num,
  output logic [1:0] p1_wins,
  output logic [1:0] p2_wins,
  output logic [6:0] timer_sec,
  output logic [1:0] round_winner,
  output logic [1:0] match_winner
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_INTRO      = 3'd1,
    S_FIGHT      = 3'd2,
    S_ROUND_END  = 3'd3,
    S_MATCH_OVER = 3'd4
  } state_t;

  localparam int unsigned MAX_A   = (INTRO_FRAMES > KO_FRAMES) ? INTRO_FRAMES : KO_FRAMES;
  localparam int unsigned CNT_MAX = (MAX_A > FRAMES_PER_SEC) ? MAX_A : FRAMES_PER_SEC;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INTRO_LAST = CW'(INTRO_FRAMES);
  localparam logic [CW-1:0] KO_LAST    = CW'(KO_FRAMES);
  localparam logic [CW-1:0] SEC_LAST   = CW'(FRAMES_PER_SEC);
  localparam logic [6:0]    TIMER_INIT = 7'(ROUND_SECONDS);
  localparam logic [1:0]    WIN_TGT    = 2'(WINS_TO_MATCH);

  state_t        state_q, state_d;
  logic          start_q;
  logic [2:0]    p1h_q, p2h_q;
  logic [CW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CW-1:0] sec_cnt_q, sec_cnt_d;
  logic [3:0]    round_q, round_d;
  logic [1:0]    p1w_q, p1w_d, p2w_q, p2w_d;
  logic [6:0]    timer_q, timer_d;
  logic [1:0]    rw_q, rw_d, mw_q, mw_d;
  logic          hrst_q, hrst_d, fe_q, fe_d;

  logic          start_rise;
  logic          ko1, ko2, decide;
  logic [1:0]    winner;
  logic [CW-1:0] frame_inc, sec_inc;

  always_comb begin
    start_rise = start & ~start_q;
    ko1        = (p1h_q == 3'd0);
    ko2        = (p2h_q == 3'd0);
    decide     = ko1 | ko2 | (timer_q == 7'd0);
    frame_inc  = frame_cnt_q + CW'(1);
    sec_inc    = sec_cnt_q + CW'(1);

    // KO outranks timeout; a timeout compares remaining health.
    winner = 2'd0;
    if (ko1 && ko2)         winner = 2'd0;
    else if (ko2)           winner = 2'd1;
    else if (ko1)           winner = 2'd2;
    else if (p1h_q > p2h_q) winner = 2'd1;
    else if (p2h_q > p1h_q) winner = 2'd2;
  end

  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    round_d     = round_q;
    p1w_d       = p1w_q;
    p2w_d       = p2w_q;
    timer_d     = timer_q;
    rw_d        = rw_q;
    mw_d        = mw_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_rise) begin
          state_d     = S_INTRO;
          round_d     = 4'd1;
          p1w_d       = '0;
          p2w_d       = '0;
          frame_cnt_d = '0;
          timer_d     = TIMER_INIT;
        end
      end
      S_INTRO: begin
        if (frame_tick) begin
          if (frame_inc == INTRO_LAST) begin
            state_d     = S_FIGHT;
            frame_cnt_d = '0;
            sec_cnt_d   = '0;
          end else begin
            frame_cnt_d = frame_inc;
          end
        end
      end
      S_FIGHT: begin
        if (decide) begin
          state_d     = S_ROUND_END;
          frame_cnt_d = '0;
          sec_cnt_d   = '0;
          rw_d        = winner;
          if (winner == 2'd1 && p1w_q != 2'd3) p1w_d = p1w_q + 2'd1;
          if (winner == 2'd2 && p2w_q != 2'd3) p2w_d = p2w_q + 2'd1;
        end else if (frame_tick) begin
          if (sec_inc == SEC_LAST) begin
            sec_cnt_d = '0;
            timer_d   = (timer_q == 7'd0) ? 7'd0 : timer_q - 7'd1;
          end else begin
            sec_cnt_d = sec_inc;
          end
        end
      end
      S_ROUND_END: begin
        if (frame_tick) begin
          if (frame_inc == KO_LAST) begin
            frame_cnt_d = '0;
            if (p1w_q == WIN_TGT) begin
              state_d = S_MATCH_OVER;
              mw_d    = 2'd1;
            end else if (p2w_q == WIN_TGT) begin
              state_d = S_MATCH_OVER;
              mw_d    = 2'd2;
            end else begin
              state_d = S_INTRO;
              round_d = (round_q == 4'd15) ? 4'd15 : round_q + 4'd1;
              rw_d    = 2'd0;
              timer_d = TIMER_INIT;
            end
          end else begin
            frame_cnt_d = frame_inc;
          end
        end
      end
      S_MATCH_OVER: begin
        if (start_rise) begin
          state_d = S_IDLE;
          round_d = 4'd1;
          p1w_d   = '0;
          p2w_d   = '0;
          rw_d    = 2'd0;
          mw_d    = 2'd0;
          timer_d = TIMER_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    hrst_d = (state_d == S_IDLE) || (state_d == S_INTRO);
    fe_d   = (state_d == S_FIGHT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b1;
      p1h_q       <= '0;
      p2h_q       <= '0;
      frame_cnt_q <= '0;
      sec_cnt_q   <= '0;
      round_q     <= 4'd1;
      p1w_q       <= '0;
      p2w_q       <= '0;
      timer_q     <= TIMER_INIT;
      rw_q        <= '0;
      mw_q        <= '0;
      hrst_q      <= 1'b1;
      fe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_q     <= start;
      p1h_q       <= player1_health;
      p2h_q       <= player2_health;
      frame_cnt_q <= frame_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      round_q     <= round_d;
      p1w_q       <= p1w_d;
      p2w_q       <= p2w_d;
      timer_q     <= timer_d;
      rw_q        <= rw_d;
      mw_q        <= mw_d;
      hrst_q      <= hrst_d;
      fe_q        <= fe_d;
    end
  end

  assign state        = state_q;
  assign round_num    = round_q;
  assign p1_wins      = p1w_q;
  assign p2_wins      = p2w_q;
  assign timer_sec    = timer_q;
  assign round_winner = rw_q;
  assign match_winner = mw_q;
  assign health_rst   = hrst_q;
  assign fight_enable = fe_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed match scenarios with literal expectations,
// then randomized play, all compared every cycle against a behavioural game model.
module tb_match_controller;
  localparam int FPS = 2, RS = 3, INTRO = 3, KOF = 2, WINS = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick, start;
  logic [2:0] p1h, p2h;
  logic       health_rst, fight_enable;
  logic [2:0] state;
  logic [3:0] round_num;
  logic [1:0] p1_wins, p2_wins, round_winner, match_winner;
  logic [6:0] timer_sec;

  int total = 0;
  int bad   = 0;

  match_controller #(
    .FRAMES_PER_SEC(FPS),
    .ROUND_SECONDS (RS),
    .INTRO_FRAMES  (INTRO),
    .KO_FRAMES     (KOF),
    .WINS_TO_MATCH (WINS)
  ) dut (
    .clk           (clk),
    .rst           (rst_n),
    .frame_tick    (frame_tick),
    .start         (start),
    .player1_health(p1h),
    .player2_health(p2h),
    .health_rst    (health_rst),
    .fight_enable  (fight_enable),
    .state         (state),
    .round_num     (round_num),
    .p1_wins       (p1_wins),
    .p2_wins       (p2_wins),
    .timer_sec     (timer_sec),
    .round_winner  (round_winner),
    .match_winner  (match_winner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Game model: phase 0 idle, 1 intro, 2 fight, 3 round over, 4 match over.
  int m_state = 0, m_round = 1, m_p1w = 0, m_p2w = 0, m_timer = RS;
  int m_rw = 0, m_mw = 0, m_hrst = 1, m_fe = 0;
  int m_frames = 0, m_sub = 0, m_h1 = 0, m_h2 = 0, m_start_prev = 1;
  int w;
  bit rise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0; m_round = 1; m_p1w = 0; m_p2w = 0; m_timer = RS;
      m_rw = 0; m_mw = 0; m_hrst = 1; m_fe = 0;
      m_frames = 0; m_sub = 0; m_h1 = 0; m_h2 = 0; m_start_prev = 1;
    end else begin
      rise = start && !m_start_prev;
      case (m_state)
        0: if (rise) begin
          m_state = 1; m_round = 1; m_p1w = 0; m_p2w = 0; m_frames = 0; m_timer = RS;
        end
        1: if (frame_tick) begin
          m_frames++;
          if (m_frames == INTRO) begin m_state = 2; m_frames = 0; m_sub = 0; end
        end
        2: if (m_h1 == 0 || m_h2 == 0 || m_timer == 0) begin
          if (m_h1 == 0 && m_h2 == 0) w = 0;
          else if (m_h2 == 0)         w = 1;
          else if (m_h1 == 0)         w = 2;
          else                        w = (m_h1 > m_h2) ? 1 : (m_h2 > m_h1) ? 2 : 0;
          m_rw = w;
          if (w == 1 && m_p1w < 3) m_p1w++;
          if (w == 2 && m_p2w < 3) m_p2w++;
          m_state = 3; m_frames = 0; m_sub = 0;
        end else if (frame_tick) begin
          m_sub++;
          if (m_sub == FPS) begin m_sub = 0; if (m_timer > 0) m_timer--; end
        end
        3: if (frame_tick) begin
          m_frames++;
          if (m_frames == KOF) begin
            m_frames = 0;
            if (m_p1w == WINS)      begin m_state = 4; m_mw = 1; end
            else if (m_p2w == WINS) begin m_state = 4; m_mw = 2; end
            else begin
              m_state = 1; m_round = (m_round < 15) ? m_round + 1 : 15; m_rw = 0; m_timer = RS;
            end
          end
        end
        4: if (rise) begin
          m_state = 0; m_round = 1; m_p1w = 0; m_p2w = 0; m_rw = 0; m_mw = 0; m_timer = RS;
        end
        default: m_state = 0;
      endcase
      m_hrst = (m_state <= 1) ? 1 : 0;
      m_fe   = (m_state == 2) ? 1 : 0;
      m_h1 = int'(p1h); m_h2 = int'(p2h); m_start_prev = int'(start);
    end
  end

  always @(negedge clk) begin
    check("state",        32'(state),        m_state);
    check("round_num",    32'(round_num),    m_round);
    check("p1_wins",      32'(p1_wins),      m_p1w);
    check("p2_wins",      32'(p2_wins),      m_p2w);
    check("timer_sec",    32'(timer_sec),    m_timer);
    check("round_winner", 32'(round_winner), m_rw);
    check("match_winner", 32'(match_winner), m_mw);
    check("health_rst",   32'(health_rst),   m_hrst);
    check("fight_enable", 32'(fight_enable), m_fe);
  end

  task automatic step(input bit ft, input bit st);
    frame_tick = ft;
    start      = st;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; frame_tick = 1'b0; p1h = 3'd5; p2h = 3'd5;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Button held through reset release must not start the match.
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1);
    check("idle_state", 32'(state), 0);
    check("idle_hrst", 32'(health_rst), 1);
    check("idle_round", 32'(round_num), 1);
    check("idle_timer", 32'(timer_sec), 3);
    check("idle_fe", 32'(fight_enable), 0);
    step(1'b0, 1'b0);
    check("idle_release", 32'(state), 0);
    step(1'b0, 1'b1);
    check("intro_entry", 32'(state), 1);
    ticks(2);
    check("intro_wait", 32'(state), 1);
    ticks(1);
    check("fight_entry", 32'(state), 2);
    check("fight_hrst", 32'(health_rst), 0);
    check("fight_fe", 32'(fight_enable), 1);

    // P1 takes two rounds by KO.
    p2h = 3'd0; step(1'b0, 1'b0);
    check("ko_sample", 32'(state), 2);
    step(1'b0, 1'b0);
    check("ko1_state", 32'(state), 3);
    check("ko1_rw", 32'(round_winner), 1);
    check("ko1_p1w", 32'(p1_wins), 1);
    check("ko1_fe", 32'(fight_enable), 0);
    p2h = 3'd5; ticks(2);
    check("r2_state", 32'(state), 1);
    check("r2_round", 32'(round_num), 2);
    check("r2_rw", 32'(round_winner), 0);
    ticks(3);
    p2h = 3'd0; step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("ko2_p1w", 32'(p1_wins), 2);
    p2h = 3'd5; ticks(2);
    check("mo_state", 32'(state), 4);
    check("mo_mw", 32'(match_winner), 1);
    step(1'b0, 1'b1);
    check("back_idle", 32'(state), 0);
    check("back_p1w", 32'(p1_wins), 0);
    check("back_mw", 32'(match_winner), 0);
    check("back_hrst", 32'(health_rst), 1);
    step(1'b0, 1'b0);

    // Timeout: higher health wins, then equal health draws.
    p1h = 3'd2; p2h = 3'd1;
    step(1'b0, 1'b1); ticks(3);
    check("to_timer3", 32'(timer_sec), 3);
    ticks(2);
    check("to_timer2", 32'(timer_sec), 2);
    ticks(4);
    check("to_timer0", 32'(timer_sec), 0);
    check("to_still_fight", 32'(state), 2);
    step(1'b0, 1'b0);
    check("to_state", 32'(state), 3);
    check("to_rw", 32'(round_winner), 1);
    check("to_p1w", 32'(p1_wins), 1);
    ticks(2);
    p1h = 3'd3; p2h = 3'd3;
    ticks(3); ticks(6); step(1'b0, 1'b0);
    check("draw_rw", 32'(round_winner), 0);
    check("draw_p1w", 32'(p1_wins), 1);
    check("draw_p2w", 32'(p2_wins), 0);
    ticks(2);
    check("draw_round", 32'(round_num), 3);

    // Double KO is a draw.
    ticks(3);
    p1h = 3'd0; p2h = 3'd0; step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("dko_state", 32'(state), 3);
    check("dko_rw", 32'(round_winner), 0);
    p1h = 3'd1; p2h = 3'd4; ticks(2);
    check("dko_round", 32'(round_num), 4);

    // P1 KO on the same cycle the timer reaches zero.
    ticks(3); ticks(5);
    check("kt_timer1", 32'(timer_sec), 1);
    p1h = 3'd0; step(1'b1, 1'b0);
    check("kt_timer0", 32'(timer_sec), 0);
    step(1'b0, 1'b0);
    check("kt_rw", 32'(round_winner), 2);
    check("kt_p2w", 32'(p2_wins), 1);
    repeat (3) step(1'b0, 1'b0);
    check("kt_once", 32'(p2_wins), 1);
    p1h = 3'd4; ticks(2); ticks(3);
    check("pre_rst_fight", 32'(state), 2);
    check("pre_rst_p1w", 32'(p1_wins), 1);

    // Asynchronous reset in the middle of a fight.
    #2 rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_p1w", 32'(p1_wins), 0);
    check("arst_hrst", 32'(health_rst), 1);
    check("arst_fe", 32'(fight_enable), 0);
    @(negedge clk);
    step(1'b1, 1'b1); step(1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    check("rel_state", 32'(state), 0);
    check("rel_round", 32'(round_num), 1);
    check("rel_timer", 32'(timer_sec), 3);
    step(1'b0, 1'b1);
    check("rel_intro", 32'(state), 1);

    // Randomized play against the model.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) p1h = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      if ($urandom_range(0, 7) == 0) p2h = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round/match sequencer for the two-player fight. It consumes the per-player health values from the health/status logic and drives that logic's clear.
- Runs the intro countdown, round timer, KO/timeout decision, win tally and match-over state.
- Gates player control via fight_enable. All timing advances on the frame tick from the video timing logic.

Parameters:
- FRAMES_PER_SEC, 60, frame_tick pulses per timer second
- ROUND_SECONDS, 99, round timer start value (1..127)
- INTRO_FRAMES, 120, frames spent in INTRO before FIGHT (>=1)
- KO_FRAMES, 90, frames spent in ROUND_END display (>=1)
- WINS_TO_MATCH, 2, round wins needed to take the match (1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- frame_tick  in  1  one-cycle pulse per video frame
- start  in  1  start/continue button, level, sampled on clk
- player1_health  in  3  P1 health, 0 = KO
- player2_health  in  3  P2 health, 0 = KO
- health_rst  out  1  active-high clear to the health/block counters
- fight_enable  out  1  high only in FIGHT; gates player FSMs
- state  out  3  0 IDLE, 1 INTRO, 2 FIGHT, 3 ROUND_END, 4 MATCH_OVER
- round_num  out  4  current round, 1-based, saturates at 15
- p1_wins  out  2  rounds won by P1
- p2_wins  out  2  rounds won by P2
- timer_sec  out  7  remaining round seconds
- round_winner  out  2  0 none/draw, 1 P1, 2 P2; valid in ROUND_END
- match_winner  out  2  0 none, 1 P1, 2 P2; valid in MATCH_OVER

Behaviour:
- Reset (rst low, asynchronous) forces:
  - state=IDLE, round_num=1, p1_wins=p2_wins=0, timer_sec=ROUND_SECONDS
  - round_winner=match_winner=0, health_rst=1, fight_enable=0
  - internal frame and second counters cleared
- Reset release is synchronous to clk; the first transition is possible on the first clk edge with rst high.
- All outputs are registered.
- Rising-edge detector on start: start_rise = start & ~start_q; start_q resets to 1, so a held button does not trigger.
- IDLE:
  - health_rst=1.
  - start_rise -> INTRO, round_num=1, wins cleared.
- INTRO:
  - health_rst=1, timer_sec=ROUND_SECONDS.
  - Frame counter counts frame_tick. On the tick that makes the count INTRO_FRAMES -> FIGHT, frame counter=0.
- FIGHT:
  - health_rst=0, fight_enable=1.
  - Second counter increments on frame_tick. On reaching FRAMES_PER_SEC it wraps to 0 and timer_sec decrements, saturating at 0.
  - KO check every clk, on registered health inputs:
    - p1==0 and p2==0 -> draw
    - p2==0 -> P1 wins
    - p1==0 -> P2 wins
  - Timeout: timer_sec==0 with no KO -> higher health wins; equal health -> draw.
  - KO has priority over timeout in the same cycle.
  - On decision -> ROUND_END next cycle:
    - round_winner set
    - winner's win count +1 (saturating at 3); draw adds nothing
    - fight_enable drops in the same cycle as the state change
- ROUND_END:
  - Health is frozen (health_rst=0).
  - Hold for KO_FRAMES frame_ticks, then:
    - if p1_wins or p2_wins == WINS_TO_MATCH -> MATCH_OVER, match_winner set
    - else -> INTRO, round_num+1 (saturate 15), round_winner=0
  - Draws always go to the next round; the match ends only on a win count.
- MATCH_OVER:
  - health_rst=0, outputs held.
  - start_rise -> IDLE next cycle (clears tallies and match_winner; health_rst=1).
- start in INTRO, FIGHT or ROUND_END is ignored.
- frame_tick coinciding with a transition cycle is consumed by the old state; counters restart at 0 in the new state.
- Asynchronous reset mid-round aborts immediately to IDLE values; no partial win is recorded.

Test Plan:
- Reset then release, no start for 10 frames -> state=0, health_rst=1, round_num=1, timer_sec=99, fight_enable=0. Hold start high through reset release -> stays IDLE until the button is released and pressed again.
- INTRO_FRAMES=3: start pulse, then 3 frame_ticks -> state=2 one clk after the 3rd tick, health_rst=0, fight_enable=1.
- In FIGHT drive p2_health=0 -> next clk state=3, round_winner=1, p1_wins=1, fight_enable=0. After KO_FRAMES ticks -> INTRO, round_num=2. A second P1 KO -> MATCH_OVER, match_winner=1. start -> IDLE with wins=0.
- FRAMES_PER_SEC=2, ROUND_SECONDS=3, healths 2 vs 1 -> timer_sec 3,2,1,0 every 2 ticks; at 0 -> round_winner=1. Repeat with equal healths -> round_winner=0, no win added, round_num increments.
- Both healths 0 in the same cycle -> draw. p1 KO on the same cycle timer hits 0 with p1 health lower -> still P2 wins, counted exactly once.
- Assert rst low mid-FIGHT with p1_wins=1 -> immediately state=0, p1_wins=0, health_rst=1; behaviour after release matches a fresh reset.
